// File: rtl/pong_pkg.sv
// Shared types, colours and default 640x480 timing for the pong renderer.
// The optional border is enabled by defining PONG_RENDER_BORDER_EN (see pong_frame_renderer).
package pong_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } position_t;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t COL_BALL   = 12'hFFF;
  localparam rgb12_t COL_LEFT   = 12'h0F0;
  localparam rgb12_t COL_RIGHT  = 12'h00F;
  localparam rgb12_t COL_BORDER = 12'hF00;
  localparam rgb12_t COL_BG     = 12'h000;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // 17-bit compare so that an object near 0xFFFF never wraps onto column/row 0.
  function automatic logic in_span(input logic [15:0] p, input logic [15:0] o,
                                   input logic [15:0] size);
    logic [16:0] p17;
    logic [16:0] lo;
    logic [16:0] hi;
    p17 = {1'b0, p};
    lo  = {1'b0, o};
    hi  = lo + {1'b0, size};
    return (p17 >= lo) && (p17 < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters, registered sync/active/pixel coordinates and the once-per-frame
// snapshot strobe (raised at the first pixel of the first blank line).
module vga_timing #(
  parameter int unsigned H_ACTIVE = pong_pkg::H_ACTIVE_DEF,
  parameter int unsigned H_FP     = pong_pkg::H_FP_DEF,
  parameter int unsigned H_SYNC   = pong_pkg::H_SYNC_DEF,
  parameter int unsigned H_BP     = pong_pkg::H_BP_DEF,
  parameter int unsigned V_ACTIVE = pong_pkg::V_ACTIVE_DEF,
  parameter int unsigned V_FP     = pong_pkg::V_FP_DEF,
  parameter int unsigned V_SYNC   = pong_pkg::V_SYNC_DEF,
  parameter int unsigned V_BP     = pong_pkg::V_BP_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] h_o,
  output logic [15:0] v_o,
  output logic        vis_o,
  output logic        capture_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        active_o,
  output logic [9:0]  pix_x_o,
  output logic [9:0]  pix_y_o,
  output logic        frame_tick_o
);

  localparam logic [15:0] H_ACT   = 16'(H_ACTIVE);
  localparam logic [15:0] H_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] HS_BEG  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END  = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] V_ACT   = 16'(V_ACTIVE);
  localparam logic [15:0] V_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] VS_BEG  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END  = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] h_q, h_d, v_q, v_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        active_q, tick_q;
  logic [9:0]  pix_x_q, pix_y_q;

  always_comb begin
    h_d = h_q + 16'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 16'd1;
    end
  end

  assign vis_o     = (h_q < H_ACT) && (v_q < V_ACT);
  assign capture_o = (h_q == '0) && (v_q == V_ACT);
  assign hsync_d   = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vsync_d   = !((v_q >= VS_BEG) && (v_q < VS_END));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
      tick_q   <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= vis_o;
      pix_x_q  <= h_q[9:0];
      pix_y_q  <= v_q[9:0];
      tick_q   <= capture_o;
    end
  end

  assign h_o          = h_q;
  assign v_o          = v_q;
  assign hsync_o      = hsync_q;
  assign vsync_o      = vsync_q;
  assign active_o     = active_q;
  assign pix_x_o      = pix_x_q;
  assign pix_y_o      = pix_y_q;
  assign frame_tick_o = tick_q;

endmodule

// File: rtl/pong_frame_renderer.sv
// Pong renderer: per-frame position snapshots, object hit tests and colour mux.
// Define PONG_RENDER_BORDER_EN to draw a 2-pixel red border around the visible area.
module pong_frame_renderer #(
  parameter int unsigned H_ACTIVE  = pong_pkg::H_ACTIVE_DEF,
  parameter int unsigned H_FP      = pong_pkg::H_FP_DEF,
  parameter int unsigned H_SYNC    = pong_pkg::H_SYNC_DEF,
  parameter int unsigned H_BP      = pong_pkg::H_BP_DEF,
  parameter int unsigned V_ACTIVE  = pong_pkg::V_ACTIVE_DEF,
  parameter int unsigned V_FP      = pong_pkg::V_FP_DEF,
  parameter int unsigned V_SYNC    = pong_pkg::V_SYNC_DEF,
  parameter int unsigned V_BP      = pong_pkg::V_BP_DEF,
  parameter int unsigned BALL_SIZE = 5,
  parameter int unsigned PADDLE_W  = 5,
  parameter int unsigned PADDLE_H  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ballPosition,
  input  logic [31:0] leftPaddlePosition,
  input  logic [31:0] rightPaddlePosition,
  output logic        frameTick,
  output logic        hsync,
  output logic        vsync,
  output logic        videoActive,
  output logic [9:0]  pixelX,
  output logic [9:0]  pixelY,
  output logic [11:0] rgb
);
  import pong_pkg::*;

  localparam logic [15:0] BALL_W = 16'(BALL_SIZE);
  localparam logic [15:0] PAD_W  = 16'(PADDLE_W);
  localparam logic [15:0] PAD_H  = 16'(PADDLE_H);

  logic [15:0] h, v;
  logic        vis, capture;
  position_t   ball_q, left_q, right_q;
  rgb12_t      rgb_q, rgb_d;
  logic        ball_hit, left_hit, right_hit;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i        (clk),
    .rst_i        (rst),
    .h_o          (h),
    .v_o          (v),
    .vis_o        (vis),
    .capture_o    (capture),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .active_o     (videoActive),
    .pix_x_o      (pixelX),
    .pix_y_o      (pixelY),
    .frame_tick_o (frameTick)
  );

  // Positions are sampled once per frame so a mid-frame update never tears the image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      rgb_q   <= COL_BG;
    end else begin
      if (capture) begin
        ball_q  <= position_t'(ballPosition);
        left_q  <= position_t'(leftPaddlePosition);
        right_q <= position_t'(rightPaddlePosition);
      end
      rgb_q <= rgb_d;
    end
  end

  assign ball_hit  = in_span(h, ball_q.x, BALL_W) && in_span(v, ball_q.y, BALL_W);
  assign left_hit  = in_span(h, left_q.x, PAD_W) && in_span(v, left_q.y, PAD_H);
  assign right_hit = in_span(h, right_q.x, PAD_W) && in_span(v, right_q.y, PAD_H);

  // Later assignments win, so lowest priority comes first.
  always_comb begin
    rgb_d = COL_BG;
`ifdef PONG_RENDER_BORDER_EN
    if ((h < 16'd2) || (h >= 16'(H_ACTIVE - 2)) || (v < 16'd2) || (v >= 16'(V_ACTIVE - 2)))
      rgb_d = COL_BORDER;
`else
`endif
    if (right_hit) rgb_d = COL_RIGHT;
    if (left_hit)  rgb_d = COL_LEFT;
    if (ball_hit)  rgb_d = COL_BALL;
    if (!vis)      rgb_d = COL_BG;
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Bench for pong_frame_renderer on a reduced 64x48 raster; every output is checked
// each cycle against a raster-index reference model plus directed pixel checks.
module tb_pong_frame_renderer;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int CAP = VA * HT;
  localparam int BS = 5, PW = 5, PH = 32;
`ifdef PONG_RENDER_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ball, lp, rp;
  logic        frameTick, hsync, vsync, videoActive;
  logic [9:0]  pixelX, pixelY;
  logic [11:0] rgb;

  int k = 0;
  int m_h = 0, m_v = 0;
  logic [31:0] m_ball = '0, m_lp = '0, m_rp = '0;
  int n_assert = 0, n_fail = 0;

  pong_frame_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BALL_SIZE(BS), .PADDLE_W(PW), .PADDLE_H(PH)
  ) dut (
    .clk(clk), .rst(rst),
    .ballPosition(ball), .leftPaddlePosition(lp), .rightPaddlePosition(rp),
    .frameTick(frameTick), .hsync(hsync), .vsync(vsync), .videoActive(videoActive),
    .pixelX(pixelX), .pixelY(pixelY), .rgb(rgb)
  );

  always #5 clk = ~clk;

  function automatic bit covers(logic [31:0] p, int w, int hgt, int x, int y);
    int ox, oy;
    ox = int'(p[31:16]);
    oy = int'(p[15:0]);
    return (x >= ox) && (x < ox + w) && (y >= oy) && (y < oy + hgt);
  endfunction

  function automatic logic [11:0] model_rgb(int x, int y, logic [31:0] b, logic [31:0] l,
                                            logic [31:0] r);
    if (x >= HA || y >= VA) return 12'h000;
    if (covers(b, BS, BS, x, y)) return 12'hFFF;
    if (covers(l, PW, PH, x, y)) return 12'h0F0;
    if (covers(r, PW, PH, x, y)) return 12'h00F;
    if (BORDER && (x < 2 || x >= HA - 2 || y < 2 || y >= VA - 2)) return 12'hF00;
    return 12'h000;
  endfunction

  function automatic logic [35:0] outs();
    return {frameTick, hsync, vsync, videoActive, pixelX, pixelY, rgb};
  endfunction

  task automatic chk(string tag, int got, int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; the outputs after edge k describe raster index k-1 since release.
  task automatic step();
    int c;
    logic [35:0] exp;
    @(posedge clk);
    k++;
    #1;
    c = (k - 1) % FRAME;
    m_h = c % HT;
    m_v = c / HT;
    exp = {(c == CAP),
           !(m_h >= HA + HF && m_h < HA + HF + HS),
           !(m_v >= VA + VF && m_v < VA + VF + VS),
           (m_h < HA && m_v < VA),
           10'(m_h), 10'(m_v),
           model_rgb(m_h, m_v, m_ball, m_lp, m_rp)};
    if (c == CAP) begin
      m_ball = ball;
      m_lp   = lp;
      m_rp   = rp;
    end
    n_assert++;
    assert (outs() === exp) else begin
      n_fail++;
      $error("FAIL cycle k=%0d got=%h exp=%h", k, outs(), exp);
    end
  endtask

  task automatic run_to(int x, int y);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_h == x && m_v == y) && n < 2 * FRAME);
    chk("run_to_timeout", n < 2 * FRAME, 1);
  endtask

  task automatic pix(string tag, int x, int y, int exp_rgb);
    run_to(x, y);
    chk(tag, rgb, exp_rgb);
  endtask

  function automatic logic [31:0] rand_pos();
    logic [15:0] x, y;
    x = ($urandom_range(0, 15) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                     : 16'($urandom_range(0, 90));
    y = 16'($urandom_range(0, 60));
    return {x, y};
  endfunction

  initial begin
    int n, first_tick, ticks, vlow, vfirst, hlow, hfirst;
    ball = {16'd32, 16'd24};
    lp   = {16'd1000, 16'd0};
    rp   = {16'd1000, 16'd0};
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 12'h000});
    rst = 1'b0;
    k = 0;

    n = 0;
    first_tick = -1;
    while (first_tick < 0 && n < 2 * FRAME) begin
      step();
      n++;
      if (frameTick) first_tick = k;
    end
    chk("first_tick_latency", first_tick, CAP + 1);

    ticks = 0; vlow = 0; vfirst = -1; hlow = 0; hfirst = -1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (frameTick) ticks++;
      if (!vsync) begin
        vlow++;
        if (vfirst < 0) vfirst = m_v;
      end
      if (m_v == 5 && !hsync) begin
        hlow++;
        if (hfirst < 0) hfirst = m_h;
      end
    end
    chk("ticks_per_frame", ticks, 1);
    chk("vsync_low_cycles", vlow, VS * HT);
    chk("vsync_first_line", vfirst, VA + VF);
    chk("hsync_low_cycles", hlow, HS);
    chk("hsync_first_pixel", hfirst, HA + HF);

    run_to(0, 10);
    ball = {16'd10, 16'd10};
    pix("old_snap_new_pos", 10, 10, 12'h000);
    pix("ball_tl", 32, 24, 12'hFFF);
    pix("ball_right_edge", 37, 24, 12'h000);
    pix("ball_br", 36, 28, 12'hFFF);
    pix("ball_below", 32, 29, 12'h000);
    pix("new_snap_new_pos", 10, 10, 12'hFFF);
    pix("new_snap_old_pos", 32, 24, 12'h000);

    ball = {16'd7, 16'd18};
    lp   = {16'd5, 16'd12};
    rp   = {16'd8, 16'd16};
    pix("left_over_right", 8, 17, 12'h0F0);
    pix("right_only", 11, 17, 12'h00F);
    pix("left_at_ball_row", 5, 18, 12'h0F0);
    pix("ball_over_left", 7, 18, 12'hFFF);
    pix("ball_over_both", 8, 18, 12'hFFF);
    pix("left_last_row", 5, 43, 12'h0F0);
    pix("below_left", 5, 44, 12'h000);

    ball = {16'hFFFE, 16'd10};
    lp   = {16'd1000, 16'd0};
    rp   = {16'd1000, 16'd0};
    pix("border_tl", 0, 0, BORDER ? 12'hF00 : 12'h000);
    for (int x = 0; x < HA; x++) begin
      run_to(x, 10);
      chk("no_wrap_line10", rgb, (BORDER && (x < 2 || x >= HA - 2)) ? 12'hF00 : 12'h000);
    end
    pix("border_br", HA - 1, VA - 1, BORDER ? 12'hF00 : 12'h000);

    for (int i = 0; i < 3 * FRAME / 2; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        ball = rand_pos();
        lp   = rand_pos();
        rp   = rand_pos();
      end
      step();
    end

    #2 rst = 1'b1;
    #1 chk("midframe_reset", outs(), {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 12'h000});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k = 0;
    m_ball = '0;
    m_lp   = '0;
    m_rp   = '0;
    first_tick = -1;
    for (int i = 0; i < FRAME + FRAME / 2; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        ball = rand_pos();
        lp   = rand_pos();
        rp   = rand_pos();
      end
      step();
      if (frameTick && first_tick < 0) first_tick = k;
    end
    chk("tick_after_reset", first_tick, CAP + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
